// File: rtl/mb_mapper_pkg.sv
// Shared constants, state encoding and lane-mask decode for the mainband TX mapper controller.
package mb_mapper_pkg;

  localparam logic [1:0] MODE_0_7  = 2'b01;
  localparam logic [1:0] MODE_8_15 = 2'b10;
  localparam logic [1:0] MODE_0_15 = 2'b11;

  localparam int BEATS_8_LANES  = 32;
  localparam int BEATS_16_LANES = 16;
  localparam int MB_LANES       = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_GAP
  } state_t;

  function automatic logic [MB_LANES-1:0] mode_to_mask(input logic [1:0] mode);
    case (mode)
      MODE_0_7:  return 16'h00FF;
      MODE_8_15: return 16'hFF00;
      MODE_0_15: return 16'hFFFF;
      default:   return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/mb_mapper_beat_cnt.sv
// Loadable beat down-counter with zero flag; holds at zero.
module mb_mapper_beat_cnt
  import mb_mapper_pkg::*;
#(
  parameter int CNT_W = $clog2(BEATS_8_LANES) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_count <= '0;
    end else if (i_load) begin
      o_count <= i_load_val;
    end else if (i_dec && !o_zero) begin
      o_count <= o_count - 1'b1;
    end
  end

  assign o_zero = (o_count == '0);

endmodule

// File: rtl/mb_tx_mapper_ctrl.sv
// Mainband TX mapper sequencer: block handshake, N-beat enable, one-cycle idle gap, lane qualifiers.
// Optional block/abort statistics counters are built when MB_MAPPER_CTRL_STATS_EN is defined.
module mb_tx_mapper_ctrl
  import mb_mapper_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int N_BYTES   = 1024,
  parameter int NUM_LANES = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [1:0]           i_functional_tx_lanes,
  input  logic                 i_abort,
  output logic                 o_enable_mapper,
  output logic [1:0]           o_mapper_mode,
  output logic                 o_data_capture,
  output logic                 o_lane_valid,
  output logic                 o_last,
  output logic [NUM_LANES-1:0] o_lane_mask,
  output logic                 o_busy,
  output logic                 o_aborted,
  output logic [15:0]          o_blk_count,
  output logic [7:0]           o_abort_count
);

  localparam int BEATS_PER_LANE_SET = N_BYTES / (WIDTH / 8);
  localparam int BEATS_HALF = BEATS_PER_LANE_SET / (NUM_LANES / 2);
  localparam int BEATS_FULL = BEATS_PER_LANE_SET / NUM_LANES;
  localparam int CNT_W      = $clog2(BEATS_8_LANES) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                 state_q, state_d;
  logic [1:0]             mode_q;
  logic [NUM_LANES-1:0]   mask_q;
  logic                   capture_q;
  logic                   lane_valid_q;
  logic                   aborted_q;
  logic                   accept;
  logic                   in_stream;
  logic [CNT_W-1:0]       beats_n;
  logic [CNT_W-1:0]       beat_cnt;
  logic                   beat_zero;

  assign in_stream = (state_q == ST_STREAM);
  assign o_ready   = (state_q == ST_IDLE) && (i_functional_tx_lanes != 2'b00) && !i_rst;
  assign accept    = i_valid && o_ready;
  assign beats_n   = (i_functional_tx_lanes == MODE_0_15) ? CNT_W'(BEATS_FULL) : CNT_W'(BEATS_HALF);

  // Counter freezes on abort so a trailing beat never sees the zero flag and raises o_last.
  mb_mapper_beat_cnt #(.CNT_W(CNT_W)) u_beat_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (accept),
    .i_load_val (beats_n),
    .i_dec      (in_stream && !i_abort),
    .o_count    (beat_cnt),
    .o_zero     (beat_zero)
  );

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_STREAM;
      ST_STREAM: if (i_abort || beat_cnt == CNT_ONE) state_d = ST_GAP;
      ST_GAP:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= 2'b00;
      mask_q       <= '0;
      capture_q    <= 1'b0;
      lane_valid_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      capture_q    <= accept;
      lane_valid_q <= in_stream;
      aborted_q    <= in_stream && i_abort;
      if (accept) begin
        mode_q <= i_functional_tx_lanes;
        mask_q <= mode_to_mask(i_functional_tx_lanes);
      end
    end
  end

  assign o_enable_mapper = in_stream;
  assign o_mapper_mode   = mode_q;
  assign o_data_capture  = capture_q;
  assign o_lane_valid    = lane_valid_q;
  assign o_last          = lane_valid_q && beat_zero;
  assign o_lane_mask     = mask_q;
  assign o_busy          = (state_q != ST_IDLE);
  assign o_aborted       = aborted_q;

`ifdef MB_MAPPER_CTRL_STATS_EN
  logic [15:0] blk_cnt_q;
  logic [7:0]  abort_cnt_q;

  // Block count wraps naturally; abort count saturates.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      blk_cnt_q   <= '0;
      abort_cnt_q <= '0;
    end else begin
      if (o_last) blk_cnt_q <= blk_cnt_q + 16'd1;
      if (aborted_q && abort_cnt_q != 8'hFF) abort_cnt_q <= abort_cnt_q + 8'd1;
    end
  end

  assign o_blk_count   = blk_cnt_q;
  assign o_abort_count = abort_cnt_q;
`else
  assign o_blk_count   = '0;
  assign o_abort_count = '0;
`endif

endmodule

// File: tb/tb_mb_tx_mapper_ctrl.sv
// Scoreboard bench for mb_tx_mapper_ctrl: a per-block timing model fills expectation queues, a monitor pops them.
module tb_mb_tx_mapper_ctrl;

`ifdef MB_MAPPER_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_functional_tx_lanes;
  logic        i_abort;
  logic        o_enable_mapper;
  logic [1:0]  o_mapper_mode;
  logic        o_data_capture;
  logic        o_lane_valid;
  logic        o_last;
  logic [15:0] o_lane_mask;
  logic        o_busy;
  logic        o_aborted;
  logic [15:0] o_blk_count;
  logic [7:0]  o_abort_count;

  mb_tx_mapper_ctrl dut (
    .i_clk                 (i_clk),
    .i_rst                 (i_rst),
    .i_valid               (i_valid),
    .o_ready               (o_ready),
    .i_functional_tx_lanes (i_functional_tx_lanes),
    .i_abort               (i_abort),
    .o_enable_mapper       (o_enable_mapper),
    .o_mapper_mode         (o_mapper_mode),
    .o_data_capture        (o_data_capture),
    .o_lane_valid          (o_lane_valid),
    .o_last                (o_last),
    .o_lane_mask           (o_lane_mask),
    .o_busy                (o_busy),
    .o_aborted             (o_aborted),
    .o_blk_count           (o_blk_count),
    .o_abort_count         (o_abort_count)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          last;
    logic [15:0] mask;
  } beat_t;

  int    en_q[$];
  int    cap_q[$];
  int    abt_q[$];
  beat_t lv_q[$];

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  mon_en   = 1'b0;
  int  exp_blk  = 0;
  int  exp_abt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // Monitor: every qualifier the DUT raises must match the head of its expectation queue.
  initial begin
    int    e;
    beat_t b;
    forever begin
      @(negedge i_clk);
      if (mon_en) begin
        if (o_enable_mapper) begin
          e = (en_q.size() != 0) ? en_q.pop_front() : -1;
          check("enable_cycle", cyc, e);
          check("busy_in_stream", o_busy, 1);
        end
        if (o_data_capture) begin
          e = (cap_q.size() != 0) ? cap_q.pop_front() : -1;
          check("capture_cycle", cyc, e);
        end
        if (o_aborted) begin
          e = (abt_q.size() != 0) ? abt_q.pop_front() : -1;
          check("aborted_cycle", cyc, e);
        end
        if (o_lane_valid) begin
          if (lv_q.size() != 0) b = lv_q.pop_front();
          else begin b.cyc = -1; b.last = 1'b0; b.mask = 16'h0; end
          check("lane_valid_cycle", cyc, b.cyc);
          check("last_flag", o_last, b.last);
          check("lane_mask", o_lane_mask, b.mask);
        end else begin
          check("last_without_valid", o_last, 0);
        end
      end
    end
  end

  // Issue one block at the current cycle T and record everything it should produce.
  task automatic run_block(input logic [1:0] mode, input int abort_k, input int rst_k,
                           input logic [1:0] chg);
    int          t, n, stop;
    logic [15:0] m;
    beat_t       b;
    n    = (mode == 2'b11) ? 16 : 32;
    m    = (mode == 2'b01) ? 16'h00FF : (mode == 2'b10) ? 16'hFF00 : 16'hFFFF;
    stop = (rst_k > 0) ? rst_k : (abort_k > 0) ? abort_k : n;
    t    = cyc;
    i_valid = 1'b1;
    i_functional_tx_lanes = mode;
    i_abort = 1'($urandom_range(0, 1));
    for (int c = t + 1; c <= t + stop; c++) en_q.push_back(c);
    cap_q.push_back(t + 1);
    if (rst_k > 0) begin
      for (int c = t + 2; c <= t + stop; c++) begin
        b.cyc = c; b.last = 1'b0; b.mask = m; lv_q.push_back(b);
      end
    end else begin
      for (int c = t + 2; c <= t + stop + 1; c++) begin
        b.cyc = c; b.last = (abort_k == 0) && (c == t + n + 1); b.mask = m; lv_q.push_back(b);
      end
      if (abort_k > 0) begin
        abt_q.push_back(t + stop + 1);
        if (exp_abt < 255) exp_abt++;
      end else begin
        exp_blk = (exp_blk + 1) & 16'hFFFF;
      end
    end
    #1 check("ready_at_accept", o_ready, 1);
    next_cycle();
    i_valid = 1'b0;
    i_functional_tx_lanes = chg;
    i_abort = 1'b0;
    for (int k = 1; k <= stop; k++) begin
      if (k == abort_k) i_abort = 1'b1;
      if (k == rst_k) i_rst = 1'b1;
      next_cycle();
      i_abort = 1'b0;
      i_rst = 1'b0;
    end
    if (rst_k > 0) begin
      exp_blk = 0;
      exp_abt = 0;
      check("rst_enable", o_enable_mapper, 0);
      check("rst_capture", o_data_capture, 0);
      check("rst_lane_valid", o_lane_valid, 0);
      check("rst_last", o_last, 0);
      check("rst_aborted", o_aborted, 0);
      check("rst_mode", o_mapper_mode, 0);
      check("rst_mask", o_lane_mask, 0);
      check("rst_blk_count", o_blk_count, 0);
      check("rst_abort_count", o_abort_count, 0);
    end else begin
      // Abort during GAP must be ignored.
      i_abort = 1'($urandom_range(0, 1));
      check("busy_in_gap", o_busy, 1);
      check("enable_low_in_gap", o_enable_mapper, 0);
      next_cycle();
      i_abort = 1'b0;
      check("mode_latched", o_mapper_mode, mode);
      check("mask_held", o_lane_mask, m);
    end
    check("idle_not_busy", o_busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, ak, gap;
    logic [1:0]  md;
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_functional_tx_lanes = 2'b11;
    i_abort = 1'b0;
    next_cycle();
    next_cycle();
    #1 check("ready_in_reset", o_ready, 0);
    check("reset_enable", o_enable_mapper, 0);
    check("reset_lane_valid", o_lane_valid, 0);
    check("reset_busy", o_busy, 0);
    check("reset_mask", o_lane_mask, 0);
    check("reset_mode", o_mapper_mode, 0);
    check("reset_blk_count", o_blk_count, 0);
    check("reset_abort_count", o_abort_count, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    mon_en = 1'b1;

    run_block(2'b11, 0, 0, 2'b11);
    run_block(2'b01, 0, 0, 2'b10);
    run_block(2'b10, 0, 0, 2'b00);

    // Mode 00 with valid held: never accepted.
    i_valid = 1'b1;
    i_functional_tx_lanes = 2'b00;
    for (int i = 0; i < 10; i++) begin
      #1 check("ready_mode00", o_ready, 0);
      next_cycle();
    end
    run_block(2'b11, 0, 0, 2'b01);

    run_block(2'b01, 0, 0, 2'b11);

    run_block(2'b11, 5, 0, 2'b11);
    check("abort_count_after_abort", o_abort_count, STATS ? 8'(exp_abt) : 8'd0);

    run_block(2'b11, 0, 10, 2'b11);
    run_block(2'b11, 0, 0, 2'b10);
    check("blk_count_after_reset", o_blk_count, STATS ? 16'(exp_blk) : 16'd0);

    for (int i = 0; i < 30; i++) begin
      md  = 2'($urandom_range(1, 3));
      n   = (md == 2'b11) ? 16 : 32;
      ak  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : 0;
      run_block(md, ak, 0, 2'($urandom));
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        i_abort = 1'($urandom_range(0, 1));
        i_functional_tx_lanes = 2'($urandom);
        next_cycle();
      end
      i_abort = 1'b0;
    end

    repeat (3) next_cycle();
    mon_en = 1'b0;
    check("enable_queue_drained", en_q.size(), 0);
    check("capture_queue_drained", cap_q.size(), 0);
    check("beat_queue_drained", lv_q.size(), 0);
    check("abort_queue_drained", abt_q.size(), 0);
    check("final_blk_count", o_blk_count, STATS ? 16'(exp_blk) : 16'd0);
    check("final_abort_count", o_abort_count, STATS ? 8'(exp_abt) : 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
